uart_rx_vote_sampler: RTL and testbench
=======================================

Name: uart_rx_vote_sampler

Overview:
- Parametrised successor to the UART RX data sampler.
- Synchronises the serial line, then takes a configurable odd number of majority-vote samples centred in each bit period.
- Works for any prescale value, not only powers of two, and flags noisy bits.
- Sits between the RX edge/bit counter and the RX FSM / deserialiser; consumes `edge_cnt` and `dat_samp_en`, produces `sampled_bit` with a one-cycle valid strobe.

Parameters:
- PRESCALE_W, 6, width of `prescale` and `edge_cnt`.
- VOTES, 3, number of samples per bit; odd, 1..15.
- SYNC_STAGES, 2, number of RX_IN synchroniser flops; minimum 1.

Ports:
- CLK  in  1  oversampling clock.
- RST  in  1  synchronous active-low reset.
- RX_IN  in  1  asynchronous serial line.
- prescale  in  PRESCALE_W  oversampling ratio (edges per bit).
- dat_samp_en  in  1  sampling enable from RX FSM.
- edge_cnt  in  PRESCALE_W  edge index within the current bit, 0..prescale-1.
- sampled_bit  out  1  voted bit value.
- sample_valid  out  1  one-cycle strobe: sampled_bit/sample_noisy updated this cycle.
- sample_noisy  out  1  votes for the last bit were not unanimous.
- cfg_err  out  1  prescale unusable for VOTES (fallback or disabled).

Behaviour:
- Reset (RST=0 at posedge CLK): all sync flops=1 (idle line), sampled_bit=1, sample_valid=0, sample_noisy=0, cfg_err=0, vote counter=0. Reset is synchronous only; the async RST edge has no effect until a clock edge.
- Sync: rx_s = RX_IN delayed SYNC_STAGES cycles. All decisions use rx_s only.
- Definitions:
  - mid = prescale>>1
  - H = VOTES>>1
  - Window = edges mid-H .. mid+H
  - Vote counter width = clog2(VOTES+1)
- Mode select, combinational from prescale each cycle:
  - prescale==0: DISABLED. No sampling; registered cfg_err=1.
  - 1 <= prescale < VOTES: SINGLE. One sample at edge_cnt==mid; registered cfg_err=1.
  - prescale >= VOTES: VOTE. Registered cfg_err=0. The window always fits within 0..prescale-1.
- VOTE mode, with dat_samp_en=1:
  - edge_cnt==mid-H: counter <= rx_s. Load, not accumulate, so stale counts from an aborted bit are discarded.
  - mid-H < edge_cnt < mid+H: counter <= counter+rx_s.
  - edge_cnt==mid+H (decision edge): total = counter+rx_s, which includes the current sample. On this clock edge:
    - sampled_bit <= (total > H)
    - sample_noisy <= (total!=0 && total!=VOTES)
    - sample_valid <= 1
    - counter <= 0
  - VOTES==1: start edge equals decision edge; decision uses rx_s directly.
- SINGLE mode, with dat_samp_en=1: at edge_cnt==mid, sampled_bit<=rx_s, sample_noisy<=0, sample_valid<=1.
- Latency: sampled_bit/sample_valid are registered and visible the cycle after the clock on which edge_cnt equals the decision edge. RX_IN-to-vote latency is SYNC_STAGES cycles.
- sample_valid is high for exactly one cycle per decision and 0 in all other cycles. It never asserts when dat_samp_en=0.
- dat_samp_en=0: counter <= 0; sampled_bit and sample_noisy hold; sample_valid=0.
- Non-monotonic edge_cnt: an edge index outside the window has no effect on the counter. Re-entering at window start reloads the counter. No decision is made without reaching the decision edge.
- prescale change mid-bit: the new mid/window applies from the next cycle; the window-start reload guarantees no cross-bit contamination.
- Arithmetic: no wrap possible, since the counter saturates logically at VOTES ≤ 2^width-1. Comparisons are unsigned at PRESCALE_W bits. mid-H is computed only in VOTE mode, where it is ≥ 0.

Test Plan:
- VOTES=3, prescale=8, RX_IN steady 1 for 2 bits → window edges 3,4,5; sample_valid pulses once per bit, the cycle after edge_cnt=5; sampled_bit=1, sample_noisy=0.
- VOTES=3, prescale=16, rx_s pattern 0,1,0 at edges 7,8,9 → sampled_bit=0, sample_noisy=1; next bit all 1 → sampled_bit=1, sample_noisy=0.
- VOTES=5, prescale=10, votes 1,1,0,1,0 at edges 3..7 → total=3 > 2 → sampled_bit=1, sample_noisy=1.
- VOTES=3, prescale=2 → cfg_err=1, SINGLE sample at edge 1; prescale=0 → cfg_err=1, sample_valid never asserts over 64 cycles.
- VOTES=3, prescale=4 → window 1..3, decision at edge 3 = prescale-1; decision is taken, sampled_bit correct. This case fails in the legacy sampler.
- Drop dat_samp_en after edge 4 of 8, then restart a bit → no sample_valid for the aborted bit; the next bit votes only its own samples. Assert RST=0 mid-bit → next cycle outputs at reset values (sampled_bit=1, sample_valid=0).

Source files
------------

// File: rtl/uart_rx_vote_sampler.sv
// UART RX data sampler. It synchronises the serial line and majority-votes VOTES samples
// centred in each bit period. Noisy bits and unusable prescale values are flagged.
module uart_rx_vote_sampler #(
  parameter int PRESCALE_W  = 6,
  parameter int VOTES       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  dat_samp_en,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  sample_noisy,
  output logic                  cfg_err
);

  localparam int CW = $clog2(VOTES + 1);
  localparam int H  = VOTES / 2;
  localparam logic [PRESCALE_W-1:0] VOTES_P = PRESCALE_W'(VOTES);
  localparam logic [PRESCALE_W-1:0] H_P     = PRESCALE_W'(H);
  localparam logic [CW-1:0]         VOTES_C = CW'(VOTES);
  localparam logic [CW-1:0]         H_C     = CW'(H);

  typedef enum logic [1:0] {MODE_DISABLED, MODE_SINGLE, MODE_VOTE} mode_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   bit_q, bit_d;
  logic                   valid_q, valid_d;
  logic                   noisy_q, noisy_d;
  logic                   cfg_err_q, cfg_err_d;

  logic                   rx_s;
  mode_e                  mode;
  logic [PRESCALE_W-1:0]  mid, win_lo, win_hi;
  logic [CW-1:0]          acc, dec_total;

  always_comb begin
    sync_d[0] = RX_IN;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign mid    = prescale >> 1;
  assign win_lo = mid - H_P;
  assign win_hi = mid + H_P;
  assign acc    = cnt_q + CW'(rx_s);
  // With a single vote the start edge is also the decision edge. The counter holds nothing useful then.
  assign dec_total = (VOTES == 1) ? CW'(rx_s) : acc;

  always_comb begin
    mode = MODE_VOTE;
    if (prescale == '0)          mode = MODE_DISABLED;
    else if (prescale < VOTES_P) mode = MODE_SINGLE;
  end

  // sample_valid: one-cycle strobe. It means sampled_bit/sample_noisy were updated by the
  // previous clock edge. There is no backpressure; the consumer must take it that cycle.
  always_comb begin
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    noisy_d   = noisy_q;
    valid_d   = 1'b0;
    cfg_err_d = (mode != MODE_VOTE);
    if (!dat_samp_en) begin
      cnt_d = '0;
    end else begin
      case (mode)
        MODE_VOTE: begin
          if (edge_cnt == win_hi) begin
            bit_d   = (dec_total > H_C);
            noisy_d = (dec_total != '0) && (dec_total != VOTES_C);
            valid_d = 1'b1;
            cnt_d   = '0;
          end else if (edge_cnt == win_lo) begin
            // Load rather than accumulate, so an aborted bit cannot leak into this one.
            cnt_d = CW'(rx_s);
          end else if ((edge_cnt > win_lo) && (edge_cnt < win_hi)) begin
            cnt_d = acc;
          end
        end
        MODE_SINGLE: begin
          cnt_d = '0;
          if (edge_cnt == mid) begin
            bit_d   = rx_s;
            noisy_d = 1'b0;
            valid_d = 1'b1;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync_q    <= '1;
      cnt_q     <= '0;
      bit_q     <= 1'b1;
      valid_q   <= 1'b0;
      noisy_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      valid_q   <= valid_d;
      noisy_q   <= noisy_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign sampled_bit  = bit_q;
  assign sample_valid = valid_q;
  assign sample_noisy = noisy_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_vote_sampler.sv
// Bench for uart_rx_vote_sampler. It uses a 3-vote and a 5-vote instance on shared inputs,
// each with its own enable, and checks against a reference expected-queue per instance.
module tb_uart_rx_vote_sampler;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic [5:0] edge_cnt = 6'd0;
  logic       en3 = 1'b0, en5 = 1'b0;
  logic       bit3, valid3, noisy3, cerr3;
  logic       bit5, valid5, noisy5, cerr5;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  // {cycle the strobe must be seen, bit, noisy}
  logic [33:0] exp3_q[$];
  logic [33:0] exp5_q[$];
  logic [33:0] e3, e5;

  // stimulus schedule: rx_s value, edge index, enable and expected decision per cycle
  int   n;
  logic line[0:511];
  int   sedge[0:511];
  logic sen[0:511];
  logic xv[0:511];
  logic xb[0:511];
  logic xn[0:511];

  uart_rx_vote_sampler #(.PRESCALE_W(6), .VOTES(3), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .prescale(prescale), .dat_samp_en(en3),
    .edge_cnt(edge_cnt), .sampled_bit(bit3), .sample_valid(valid3),
    .sample_noisy(noisy3), .cfg_err(cerr3));

  uart_rx_vote_sampler #(.PRESCALE_W(6), .VOTES(5), .SYNC_STAGES(2)) dut5 (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .prescale(prescale), .dat_samp_en(en5),
    .edge_cnt(edge_cnt), .sampled_bit(bit5), .sample_valid(valid5),
    .sample_noisy(noisy5), .cfg_err(cerr5));

  // clock / cycle counter
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // scoreboards
  always @(negedge CLK) begin
    if (valid3) begin
      compared++;
      if (exp3_q.size() == 0) begin
        mismatched++;
        $display("FAIL sb3_unexpected: valid at cycle %0d, required no strobe", cyc);
      end else begin
        e3 = exp3_q.pop_front();
        if ({cyc[31:0], bit3, noisy3} !== e3) begin
          mismatched++;
          $display("FAIL sb3: got cycle=%0d bit=%b noisy=%b, required cycle=%0d bit=%b noisy=%b",
                   cyc, bit3, noisy3, e3[33:2], e3[1], e3[0]);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (valid5) begin
      compared++;
      if (exp5_q.size() == 0) begin
        mismatched++;
        $display("FAIL sb5_unexpected: valid at cycle %0d, required no strobe", cyc);
      end else begin
        e5 = exp5_q.pop_front();
        if ({cyc[31:0], bit5, noisy5} !== e5) begin
          mismatched++;
          $display("FAIL sb5: got cycle=%0d bit=%b noisy=%b, required cycle=%0d bit=%b noisy=%b",
                   cyc, bit5, noisy5, e5[33:2], e5[1], e5[0]);
        end
      end
    end
  end

  // driver tasks
  task automatic drive_cycle(input logic rx, input int e, input logic en, input int which);
    @(negedge CLK);
    RX_IN    = rx;
    edge_cnt = 6'(e);
    en3      = en && (which == 0);
    en5      = en && (which == 1);
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) line[i] = 1'($urandom_range(0, 1));
  endtask

  // Reference model: whole bits of length p, edges 0..p-1, enable always high.
  task automatic build_bits(input int p, input int nbits, input int v);
    int mid, h, ones, c;
    prescale = 6'(p);
    n = nbits * p;
    mid = p / 2;
    h = v / 2;
    for (int b = 0; b < nbits; b++) begin
      for (int e = 0; e < p; e++) begin
        c = b * p + e;
        sedge[c] = e;
        sen[c] = 1'b1;
        xv[c] = 1'b0;
        xb[c] = 1'b0;
        xn[c] = 1'b0;
      end
      if (p >= v) begin
        ones = 0;
        for (int k = -h; k <= h; k++) ones += int'(line[b * p + mid + k]);
        c = b * p + mid + h;
        xv[c] = 1'b1;
        xb[c] = (ones > h);
        xn[c] = (ones != 0) && (ones != v);
      end else if (p > 0) begin
        c = b * p + mid;
        xv[c] = 1'b1;
        xb[c] = line[c];
        xn[c] = 1'b0;
      end
    end
  endtask

  // RX_IN leads rx_s by two synchroniser cycles, so line[c] is driven two cycles early.
  task automatic run_sched(input int which, input string name);
    logic [33:0] ent;
    drive_cycle(line[0], 0, 1'b0, which);
    drive_cycle(line[1], 0, 1'b0, which);
    for (int c = 0; c < n; c++) begin
      drive_cycle((c + 2 < n) ? line[c + 2] : 1'b1, sedge[c], sen[c], which);
      if (xv[c]) begin
        ent = {32'(cyc + 1), xb[c], xn[c]};
        if (which == 0) exp3_q.push_back(ent);
        else            exp5_q.push_back(ent);
      end
    end
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 0, 1'b0, which);
    compared++;
    if (exp3_q.size() + exp5_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s_drain: %0d strobes missing, required 0", name, exp3_q.size() + exp5_q.size());
      exp3_q.delete();
      exp5_q.delete();
    end
  endtask

  // tests
  task automatic test_reset();
    RST = 1'b0;
    prescale = 6'd8;
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    compared++;
    if ({bit3, valid3, noisy3, cerr3} !== 4'b1000) begin
      mismatched++;
      $display("FAIL reset3: got bit/valid/noisy/cfg=%b, required 1000", {bit3, valid3, noisy3, cerr3});
    end
    compared++;
    if ({bit5, valid5, noisy5, cerr5} !== 4'b1000) begin
      mismatched++;
      $display("FAIL reset5: got bit/valid/noisy/cfg=%b, required 1000", {bit5, valid5, noisy5, cerr5});
    end
    RST = 1'b1;
  endtask

  task automatic test_steady();
    for (int i = 0; i < 16; i++) line[i] = 1'b1;
    build_bits(8, 2, 3);
    run_sched(0, "steady");
    compared++;
    if (cerr3 !== 1'b0) begin
      mismatched++;
      $display("FAIL steady_cfg_err: got %b, required 0", cerr3);
    end
  endtask

  task automatic test_noisy();
    for (int i = 0; i < 32; i++) line[i] = 1'b1;
    line[7] = 1'b0;
    line[8] = 1'b1;
    line[9] = 1'b0;
    build_bits(16, 2, 3);
    run_sched(0, "noisy");
  endtask

  task automatic test_votes5();
    fill_random(20);
    line[3] = 1'b1; line[4] = 1'b1; line[5] = 1'b0; line[6] = 1'b1; line[7] = 1'b0;
    build_bits(10, 2, 5);
    run_sched(1, "votes5");
  endtask

  task automatic test_window_edge();
    fill_random(24);
    build_bits(4, 6, 3);
    run_sched(0, "win_edge");
    fill_random(20);
    build_bits(5, 4, 5);
    run_sched(1, "win_edge5");
  endtask

  task automatic test_random_prescale();
    int plist[5] = '{5, 7, 9, 12, 13};
    for (int i = 0; i < 5; i++) begin
      fill_random(plist[i] * 4);
      build_bits(plist[i], 4, 3);
      run_sched(0, "rand3");
      fill_random(plist[i] * 4);
      build_bits(plist[i], 4, 5);
      run_sched(1, "rand5");
    end
  endtask

  task automatic test_single();
    fill_random(16);
    build_bits(2, 8, 3);
    run_sched(0, "single3");
    compared++;
    if (cerr3 !== 1'b1) begin
      mismatched++;
      $display("FAIL single3_cfg_err: got %b, required 1", cerr3);
    end
    fill_random(12);
    build_bits(3, 4, 5);
    run_sched(1, "single5");
    compared++;
    if (cerr5 !== 1'b1) begin
      mismatched++;
      $display("FAIL single5_cfg_err: got %b, required 1", cerr5);
    end
  endtask

  task automatic test_disabled();
    int nval = 0;
    prescale = 6'd0;
    for (int i = 0; i < 64; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'b1, 0);
      if (valid3) nval++;
    end
    drive_cycle(1'b1, 0, 1'b0, 0);
    if (valid3) nval++;
    compared++;
    if (nval != 0) begin
      mismatched++;
      $display("FAIL disabled_valid: got %0d strobes, required 0", nval);
    end
    compared++;
    if (cerr3 !== 1'b1) begin
      mismatched++;
      $display("FAIL disabled_cfg_err: got %b, required 1", cerr3);
    end
  endtask

  task automatic test_abort();
    prescale = 6'd8;
    n = 16;
    for (int c = 0; c < 16; c++) begin
      xv[c] = 1'b0; xb[c] = 1'b0; xn[c] = 1'b0;
      line[c] = 1'b1;
    end
    for (int c = 0; c < 5; c++) begin sedge[c] = c; sen[c] = 1'b1; end
    for (int c = 5; c < 8; c++) begin sedge[c] = 0; sen[c] = 1'b0; end
    for (int c = 8; c < 16; c++) begin
      sedge[c] = c - 8;
      sen[c] = 1'b1;
      line[c] = 1'b0;
    end
    line[12] = 1'b1;
    // restarted bit votes 0,1,0 at edges 3,4,5 -> 0, noisy
    xv[13] = 1'b1; xb[13] = 1'b0; xn[13] = 1'b1;
    run_sched(0, "abort");
    compared++;
    if ({bit3, noisy3} !== 2'b01) begin
      mismatched++;
      $display("FAIL abort_hold: got bit/noisy=%b, required 01", {bit3, noisy3});
    end
  endtask

  task automatic test_reset_midbit();
    prescale = 6'd8;
    for (int e = 0; e < 5; e++) drive_cycle(1'b0, e, 1'b1, 0);
    drive_cycle(1'b0, 5, 1'b1, 0);
    RST = 1'b0;
    @(negedge CLK);
    compared++;
    if ({bit3, valid3, noisy3} !== 3'b100) begin
      mismatched++;
      $display("FAIL reset_midbit: got bit/valid/noisy=%b, required 100", {bit3, valid3, noisy3});
    end
    RST = 1'b1;
    en3 = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_steady();
    test_noisy();
    test_votes5();
    test_window_edge();
    test_random_prescale();
    test_single();
    test_disabled();
    test_abort();
    test_reset_midbit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
